// File: rtl/jk_bank_sequencer.sv
// Command sequencer for a bank of JK master-slave flip-flops: drives J/K for one
// cycle per step, lets the slave settle, then verifies Q feedback.
//
//   state  | meaning
//   IDLE   | ready for a command, j=k=0
//   DRIVE  | j/k asserted for one cycle, snapshot q_fb and expected value
//   SETTLE | j=k=0 for SETTLE_CYC cycles while the slave updates
//   CHECK  | compare q_fb with expected, pulse done/err or start next step
module jk_bank_sequencer #(
  parameter int WIDTH      = 4,
  parameter int CW         = 8,
  parameter int SETTLE_CYC = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CW-1:0]    cmd_count,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] result
);

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_SET  = 3'd1;
  localparam logic [2:0] OP_CLR  = 3'd2;
  localparam logic [2:0] OP_TGL  = 3'd3;
  localparam logic [2:0] OP_LOAD = 3'd4;
  localparam logic [2:0] OP_INC  = 3'd5;
  localparam logic [2:0] OP_DEC  = 3'd6;
  localparam logic [2:0] OP_RSV  = 3'd7;

  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SW-1:0] SETTLE_LOAD = SW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, SETTLE, CHECK} state_t;

  state_t           state, state_nxt;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] data_r;
  logic [CW-1:0]    steps_r;
  logic             verify_r;
  logic [WIDTH-1:0] expected_r;
  logic [SW-1:0]    settle_cnt;

  logic             accept;
  logic             step_op_in;
  logic             nodrive_in;
  logic             match;
  logic             last_step;
  logic [WIDTH-1:0] inc_m, dec_m;
  logic [WIDTH-1:0] drive_j, drive_k, exp_next;

  assign accept     = cmd_valid & cmd_ready;
  assign step_op_in = (cmd_op == OP_INC) || (cmd_op == OP_DEC);
  assign nodrive_in = (cmd_op == OP_NOP) || (cmd_op == OP_RSV) ||
                      (step_op_in && (cmd_count == '0));
  assign match      = (q_fb == expected_r);
  assign last_step  = (steps_r <= CW'(1));

  // Toggle masks: a bit flips when every lower bit is 1 (INC) or 0 (DEC).
  always_comb begin : p_mask
    logic run_i, run_d;
    inc_m = '0;
    dec_m = '0;
    run_i = 1'b1;
    run_d = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      inc_m[i] = run_i;
      dec_m[i] = run_d;
      run_i    = run_i & q_fb[i];
      run_d    = run_d & ~q_fb[i];
    end
  end

  always_comb begin
    drive_j  = '0;
    drive_k  = '0;
    exp_next = q_fb;
    case (op_r)
      OP_SET:  begin drive_j = data_r; exp_next = q_fb | data_r; end
      OP_CLR:  begin drive_k = data_r; exp_next = q_fb & ~data_r; end
      OP_TGL:  begin drive_j = data_r; drive_k = data_r; exp_next = q_fb ^ data_r; end
      OP_LOAD: begin drive_j = data_r; drive_k = ~data_r; exp_next = data_r; end
      OP_INC:  begin drive_j = inc_m; drive_k = inc_m; exp_next = q_fb + WIDTH'(1); end
      OP_DEC:  begin drive_j = dec_m; drive_k = dec_m; exp_next = q_fb - WIDTH'(1); end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = nodrive_in ? CHECK : DRIVE;
      DRIVE:   state_nxt = SETTLE;
      SETTLE:  if (settle_cnt == '0) state_nxt = CHECK;
      CHECK:   state_nxt = (verify_r && match && !last_step) ? DRIVE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == IDLE);
    busy      = (state != IDLE);
    j         = '0;
    k         = '0;
    done      = 1'b0;
    err       = 1'b0;
    if (state == DRIVE) begin
      j = drive_j;
      k = drive_k;
    end
    if (state == CHECK) begin
      done = verify_r ? (match && last_step) : (op_r != OP_RSV);
      err  = verify_r ? !match : (op_r == OP_RSV);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r       <= OP_NOP;
      data_r     <= '0;
      steps_r    <= '0;
      verify_r   <= 1'b0;
      expected_r <= '0;
      settle_cnt <= '0;
      result     <= '0;
    end else begin
      if (accept) begin
        op_r     <= cmd_op;
        data_r   <= cmd_data;
        steps_r  <= step_op_in ? cmd_count : CW'(1);
        verify_r <= !nodrive_in;
      end
      if (state == DRIVE) begin
        expected_r <= exp_next;
        settle_cnt <= SETTLE_LOAD;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end
      if (state == CHECK) begin
        result <= q_fb;
        if (verify_r && match && !last_step) steps_r <= steps_r - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_jk_bank_sequencer.sv
// Bench for jk_bank_sequencer: behavioural JK bank plus a command-level
// reference model; directed scenarios followed by randomized commands.
module tb_jk_bank_sequencer;
  localparam int WIDTH      = 4;
  localparam int CW         = 8;
  localparam int SETTLE_CYC = 1;
  localparam int PER        = 2 + SETTLE_CYC;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_data = '0;
  logic [CW-1:0]    cmd_count = '0;
  logic [WIDTH-1:0] j, k, q_fb, result;
  logic             busy, done, err;

  logic [WIDTH-1:0] master = '0;
  logic [WIDTH-1:0] bank_q = '0;
  bit               stuck = 1'b0;
  logic [WIDTH-1:0] stuck_val = '0;
  logic [WIDTH-1:0] model_q = '0;

  int n_tests = 0;
  int n_fail  = 0;

  jk_bank_sequencer #(.WIDTH(WIDTH), .CW(CW), .SETTLE_CYC(SETTLE_CYC)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_count(cmd_count),
    .j(j), .k(k), .q_fb(q_fb), .busy(busy), .done(done), .err(err),
    .result(result)
  );

  always #5 clk = ~clk;

  // Master-slave JK bank: master captures on posedge, slave follows on negedge.
  always @(posedge clk or posedge rst)
    if (rst) master <= '0;
    else     master <= (j & ~bank_q) | (~k & bank_q);

  always @(negedge clk or posedge rst)
    if (rst) bank_q <= '0;
    else     bank_q <= master;

  assign q_fb = stuck ? stuck_val : bank_q;

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] ref_next(input logic [2:0] op, input logic [WIDTH-1:0] s,
                                                input logic [WIDTH-1:0] d);
    int v;
    v = int'(s);
    case (op)
      3'd1: return s | d;
      3'd2: return s & ~d;
      3'd3: return s ^ d;
      3'd4: return d;
      3'd5: return WIDTH'((v + 1) % (1 << WIDTH));
      3'd6: return WIDTH'((v + (1 << WIDTH) - 1) % (1 << WIDTH));
      default: return s;
    endcase
  endfunction

  // Expected {j,k}; counter steps toggle exactly the bits that differ from the neighbour value.
  function automatic logic [2*WIDTH-1:0] ref_jk(input logic [2:0] op, input logic [WIDTH-1:0] s,
                                               input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] m;
    m = s ^ ref_next(op, s, d);
    case (op)
      3'd1: return {d, {WIDTH{1'b0}}};
      3'd2: return {{WIDTH{1'b0}}, d};
      3'd3: return {d, d};
      3'd4: return {d, ~d};
      3'd5, 3'd6: return {m, m};
      default: return '0;
    endcase
  endfunction

  task automatic junk_inputs();
    cmd_valid = 1'($urandom_range(0, 1));
    cmd_op    = 3'($urandom);
    cmd_data  = WIDTH'($urandom);
    cmd_count = CW'($urandom);
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [WIDTH-1:0] d, input logic [CW-1:0] cnt);
    logic [WIDTH-1:0] step_s[$];
    logic [WIDTH-1:0] s, e, exp_res;
    logic [2*WIDTH-1:0] jk_exp;
    bit is_step, drove, exp_err;
    int lat, nsteps, idx, ph;
    is_step = (op == 3'd5) || (op == 3'd6);
    drove   = ((op >= 3'd1) && (op <= 3'd4)) || (is_step && (cnt != 0));
    exp_err = 1'b0;
    s = stuck ? stuck_val : model_q;
    if (!drove) begin
      lat     = 1;
      exp_err = (op == 3'd7);
      exp_res = s;
    end else begin
      nsteps = is_step ? int'(cnt) : 1;
      lat = 0;
      for (int i = 0; i < nsteps; i++) begin
        step_s.push_back(s);
        e = ref_next(op, s, d);
        lat += PER;
        s = stuck ? stuck_val : e;
        if (s != e) begin
          exp_err = 1'b1;
          break;
        end
      end
      exp_res = s;
      if (!stuck) model_q = s;
    end

    @(negedge clk);
    chk_val("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    cmd_count = cnt;
    @(posedge clk);
    #1;
    junk_inputs();
    for (int n = 1; n <= lat; n++) begin
      @(negedge clk);
      idx = (n - 1) / PER;
      ph  = (n - 1) % PER;
      jk_exp = '0;
      if (drove && (ph == 0)) jk_exp = ref_jk(op, step_s[idx], d);
      chk_val("jk", {j, k}, jk_exp);
      chk_val("busy", busy, 1);
      chk_val("done_err", {done, err}, (n == lat) ? (exp_err ? 2'b01 : 2'b10) : 2'b00);
      if (n < lat) junk_inputs();
      else cmd_valid = 1'b0;
    end
    @(negedge clk);
    chk_val("ready_after", cmd_ready, 1);
    chk_val("busy_after", busy, 0);
    chk_val("pulse_after", {done, err}, 0);
    chk_val("jk_after", {j, k}, 0);
    chk_val("result", result, exp_res);
  endtask

  initial begin
    logic [2:0] op;
    logic [WIDTH-1:0] d;
    logic [CW-1:0] cnt;

    repeat (2) @(negedge clk);
    chk_val("rst_ready", cmd_ready, 1);
    chk_val("rst_busy", busy, 0);
    chk_val("rst_jk", {j, k}, 0);
    chk_val("rst_pulse", {done, err}, 0);
    chk_val("rst_result", result, 0);
    rst = 1'b0;

    run_cmd(3'd4, 4'b1010, 0);
    chk_val("tp_load", result, 4'b1010);
    run_cmd(3'd4, 4'b0101, 0);
    run_cmd(3'd1, 4'b1000, 0);
    chk_val("tp_set", result, 4'b1101);
    run_cmd(3'd2, 4'b0001, 0);
    chk_val("tp_clr", result, 4'b1100);
    run_cmd(3'd3, 4'b0110, 0);
    chk_val("tp_tgl", result, 4'b1010);
    run_cmd(3'd4, 4'b1110, 0);
    run_cmd(3'd5, 4'b0000, 3);
    chk_val("tp_inc_wrap", result, 4'b0001);
    run_cmd(3'd4, 4'b0000, 0);
    run_cmd(3'd6, 4'b0000, 2);
    chk_val("tp_dec_wrap", result, 4'b1110);

    stuck = 1'b1;
    stuck_val = 4'b0000;
    run_cmd(3'd1, 4'b0001, 0);
    run_cmd(3'd5, 4'b0000, 5);
    stuck = 1'b0;
    run_cmd(3'd4, 4'b0011, 0);
    run_cmd(3'd7, 4'b1111, 0);
    run_cmd(3'd0, 4'b1111, 0);
    run_cmd(3'd5, 4'b1111, 0);

    // Reset during the first DRIVE of a multi-step INC.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 3'd5;
    cmd_data  = '0;
    cmd_count = 4;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk_val("rst_mid_drive", {j, k}, ref_jk(3'd5, model_q, '0));
    #2 rst = 1'b1;
    #1;
    chk_val("rst_mid_jk", {j, k}, 0);
    chk_val("rst_mid_busy", busy, 0);
    chk_val("rst_mid_pulse", {done, err}, 0);
    @(negedge clk);
    rst = 1'b0;
    model_q = '0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      chk_val("rst_mid_quiet", {done, err, cmd_ready}, 3'b001);
    end

    for (int t = 0; t < 150; t++) begin
      op  = 3'($urandom_range(0, 7));
      d   = WIDTH'($urandom);
      cnt = CW'($urandom_range(0, 5));
      if ($urandom_range(0, 9) == 0) begin
        stuck = 1'b1;
        stuck_val = WIDTH'($urandom);
        run_cmd(op, d, cnt);
        stuck = 1'b0;
        run_cmd(3'd4, WIDTH'($urandom), 0);
      end else begin
        run_cmd(op, d, cnt);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/jk_bank_sequencer.md
# jk_bank_sequencer

Command-driven controller for a WIDTH-bit bank of JK master-slave flip-flops. It accepts one command at a time over a valid/ready handshake and drives per-bit J/K inputs for exactly one cycle per step. It then waits for the slave stage to settle and verifies the bank's Q feedback against the expected value. It sits between the control processor and the flip-flop bank and is the only driver of the bank's J/K inputs.

## Interface
- WIDTH, 4, number of flip-flops in the bank
- CW, 8, width of the step-count field
- SETTLE_CYC, 1, idle cycles between drive and check; must be ≥1
- clk  input  1  clock; controller logic is posedge only
- rst  input  1  asynchronous, active-high reset; shared with the flip-flop bank
- cmd_valid  input  1  command present
- cmd_ready  output  1  controller can accept a command
- cmd_op  input  3  opcode
- cmd_data  input  WIDTH  bit mask or load value
- cmd_count  input  CW  step count for INC/DEC
- j  output  WIDTH  J inputs to the bank
- k  output  WIDTH  K inputs to the bank
- q_fb  input  WIDTH  slave Q outputs of the bank
- busy  output  1  command in progress
- done  output  1  one-cycle pulse: command completed and verified
- err  output  1  one-cycle pulse: verify mismatch or illegal opcode
- result  output  WIDTH  q_fb captured at the last CHECK

## Operation
- States: IDLE, DRIVE, SETTLE, CHECK.
- IDLE: cmd_ready=1, busy=0, j=k=0.
  - On cmd_valid&cmd_ready: latch op, data and count; go to DRIVE.
  - Exceptions: op 0, op 7, and INC/DEC with count 0 go straight to CHECK.
- Opcodes, with snapshot s = q_fb sampled in DRIVE:
  - 0 NOP: no drive; done pulse.
  - 1 SET: j=data, k=0; expected s|data.
  - 2 CLR: j=0, k=data; expected s&~data.
  - 3 TGL: j=k=data; expected s^data.
  - 4 LOAD: j=data, k=~data; expected data.
  - 5 INC: j=k=m, where m[i]=&s[i-1:0] and m[0]=1; expected s+1 mod 2^WIDTH.
  - 6 DEC: j=k=m, where m[i]=&~s[i-1:0] and m[0]=1; expected s-1 mod 2^WIDTH.
  - 7 reserved: no drive; err pulse.
- DRIVE: j/k asserted for this single cycle only; capture s and expected. Next state SETTLE.
- SETTLE: j=k=0 for SETTLE_CYC cycles. Next state CHECK.
- CHECK: result<=q_fb.
  - q_fb≠expected: err pulse; abort any remaining INC/DEC steps; go to IDLE.
  - q_fb matches and remaining steps >0: decrement the step counter; go to DRIVE. No done pulse between steps.
  - q_fb matches, final step: done pulse; go to IDLE.
- INC/DEC wrap: all-ones+1 → 0 and 0−1 → all-ones. The wrap is not an error.
- done and err are never asserted together.
- j and k are never nonzero outside DRIVE.

## Timing
- Reset values: cmd_ready=1, busy=0, j=0, k=0, done=0, err=0, result=0, state IDLE.
- rst asserted mid-operation: j/k clear immediately (asynchronous); the command is dropped and no done/err pulse is produced.
- Single-step command with SETTLE_CYC=1:
  - t: accept.
  - t+1: DRIVE.
  - t+2: SETTLE.
  - t+3: CHECK; done/err asserted.
  - t+4: cmd_ready=1.
- Step cost is 2+SETTLE_CYC cycles. INC with count N finishes N·(2+SETTLE_CYC) cycles after acceptance.
- NOP, op 7 and count 0: pulse at t+1; cmd_ready at t+2.
- Bank timing: the master samples at the posedge ending DRIVE and the slave updates at the following negedge. q_fb is therefore stable before the posedge that ends SETTLE.
- cmd_ready deasserts the cycle after acceptance. cmd_valid while busy is ignored and produces no queuing.
- busy=1 from the cycle after acceptance through the CHECK cycle of the final step.

## Test plan
- Reset, then LOAD 4'b1010 → j=1010, k=0101 for one cycle; done at t+3; result=1010.
- After LOAD 0101: SET 1000, then CLR 0001, then TGL 0110 → results 1101, 1100, 1010; each command gets exactly one done pulse.
- LOAD 1110, then INC count 3 → bank passes 1111, 0000, 0001; one done at 3·3 cycles after acceptance; result=0001.
- DEC count 2 from 0000 → 1111, then 1110; done; no err.
- Fault: force q_fb stuck at 0000 and issue SET 0001 → err at the CHECK cycle; no done. Repeat with INC count 5 → abort after the first step.
- op 7 → err at t+1, with j=k=0 throughout. Then assert rst during the DRIVE of INC count 4 → j=k=0 immediately, no pulse, and cmd_ready=1 after release.
